// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//   Decode-to-execute stage on the read side of the 32-entry register file.
//   Drives the register file read addresses, picks each operand from x0,
//   same-cycle write-back data or register file data, and captures the operands
//   into a one-deep output register. A busy-bit scoreboard tracks pending
//   destination writes and stalls any instruction that reads a busy register.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          decode handshake (in_ready is combinational)
//   in_rs1, in_rs2, in_rd,
//   in_rd_we                   instruction fields from decode
//   rf_a0, rf_a1               register file read addresses (combinational)
//   rf_q0, rf_q1               register file read data
//   wb_en, wb_addr, wb_data    write-back port, shared with the register file
//   out_valid/out_ready        execute handshake
//   out_op1, out_op2,
//   out_rd, out_rd_we          registered operands and destination fields
// -----------------------------------------------------------------------------
module operand_fetch #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [AW-1:0]   in_rd,
    input  logic            in_rd_we,

    output logic [AW-1:0]   rf_a0,
    output logic [AW-1:0]   rf_a1,
    input  logic [XLEN-1:0] rf_q0,
    input  logic [XLEN-1:0] rf_q1,

    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [AW-1:0]   out_rd,
    output logic            out_rd_we
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NREG-1:0] busy_q,   busy_d;
    logic            valid_q,  valid_d;
    logic [XLEN-1:0] op1_q,    op1_d;
    logic [XLEN-1:0] op2_q,    op2_d;
    logic [AW-1:0]   rd_q,     rd_d;
    logic            rd_we_q,  rd_we_d;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    // Write-back targets register r this cycle (x0 is never a real target).
    function automatic logic wb_hit(input logic [AW-1:0] r,
                                    input logic          en,
                                    input logic [AW-1:0] addr);
        return en && (addr == r) && (r != '0);
    endfunction

    // Pick the operand value: x0 reads zero, then the in-flight write-back,
    // then whatever the register file returned.
    function automatic logic [XLEN-1:0] op_sel(input logic [AW-1:0]   rs,
                                               input logic [XLEN-1:0] rfq,
                                               input logic            en,
                                               input logic [AW-1:0]   addr,
                                               input logic [XLEN-1:0] data);
        logic [XLEN-1:0] v;
        if (rs == '0)                  v = '0;
        else if (wb_hit(rs, en, addr)) v = data;
        else                           v = rfq;
        return v;
    endfunction

    // -------------------------------------------------------------------------
    // Combinational handshake and hazard detection
    // -------------------------------------------------------------------------
    logic hazard1;
    logic hazard2;
    logic slot_free;
    logic accept;

    assign rf_a0 = in_rs1;
    assign rf_a1 = in_rs2;

    // A busy source is released in the same cycle its write-back arrives,
    // because the write-back data is forwarded directly.
    assign hazard1   = busy_q[in_rs1] && !wb_hit(in_rs1, wb_en, wb_addr);
    assign hazard2   = busy_q[in_rs2] && !wb_hit(in_rs2, wb_en, wb_addr);
    assign slot_free = !valid_q || out_ready;
    assign in_ready  = slot_free && !hazard1 && !hazard2;
    assign accept    = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Next-state logic: scoreboard and output register
    // -------------------------------------------------------------------------
    always_comb begin
        busy_d  = busy_q;
        valid_d = valid_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        rd_d    = rd_q;
        rd_we_d = rd_we_q;

        // Clear before set so a same-cycle new producer keeps the bit busy.
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (accept && in_rd_we && (in_rd != '0)) begin
            busy_d[in_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (accept) begin
            valid_d = 1'b1;
            op1_d   = op_sel(in_rs1, rf_q0, wb_en, wb_addr, wb_data);
            op2_d   = op_sel(in_rs2, rf_q1, wb_en, wb_addr, wb_data);
            rd_d    = in_rd;
            rd_we_d = in_rd_we;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            rd_q    <= '0;
            rd_we_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            valid_q <= valid_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rd_q    <= rd_d;
            rd_we_q <= rd_we_d;
        end
    end

    assign out_valid = valid_q;
    assign out_op1   = op1_q;
    assign out_op2   = op2_q;
    assign out_rd    = rd_q;
    assign out_rd_we = rd_we_q;

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
//   Directed bench for operand_fetch with a small register file model.
//   Inputs change 1 time unit after a rising edge; combinational outputs are
//   checked 1 unit later, registered outputs 1 unit after the next edge.
// -----------------------------------------------------------------------------
module tb_operand_fetch;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_rs1, in_rs2, in_rd;
    logic            in_rd_we;
    logic [AW-1:0]   rf_a0, rf_a1;
    logic [XLEN-1:0] rf_q0, rf_q1;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_op1, out_op2;
    logic [AW-1:0]   out_rd;
    logic            out_rd_we;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    // Register file model: write lands at the clock edge, read is combinational.
    logic [XLEN-1:0] rf_mem [NREG];
    assign rf_q0 = rf_mem[rf_a0];
    assign rf_q1 = rf_mem[rf_a1];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) rf_mem[i] <= '0;
            rf_mem[5] <= 32'h0000_1234;
        end else if (wb_en && wb_addr != '0) begin
            rf_mem[wb_addr] <= wb_data;
        end
    end

    operand_fetch #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_rd_we  (in_rd_we),
        .rf_a0     (rf_a0),
        .rf_a1     (rf_a1),
        .rf_q0     (rf_q0),
        .rf_q1     (rf_q1),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op1   (out_op1),
        .out_op2   (out_op2),
        .out_rd    (out_rd),
        .out_rd_we (out_rd_we)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic we);
        in_valid = v;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_rd_we = we;
    endtask

    task automatic wb(input logic en, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        wb(1'b0, 5'd0, 32'h0);

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op1",       out_op1,        32'd0);
        chk("rst_op2",       out_op2,        32'd0);
        chk("rst_rd",        32'(out_rd),    32'd0);
        chk("rst_rd_we",     32'(out_rd_we), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        step();
        rst = 1'b0;

        // 1: plain read of x5 and x0
        drive(1'b1, 5'd5, 5'd0, 5'd1, 1'b0);
        #1;
        chk("t1_rf_a0",    32'(rf_a0),    32'd5);
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_op1",       out_op1,        32'h1234);
        chk("t1_op2",       out_op2,        32'd0);

        // 2: producer of x7, then a consumer stalls until write-back
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
        step();
        chk("t2_rd",    32'(out_rd),    32'd7);
        chk("t2_rd_we", 32'(out_rd_we), 32'd1);
        drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
        #1;
        chk("t2_stall_a", 32'(in_ready), 32'd0);
        step();
        chk("t2_drain_valid", 32'(out_valid), 32'd0);
        chk("t2_stall_b",     32'(in_ready),  32'd0);
        wb(1'b1, 5'd7, 32'hCAFE);
        #1;
        chk("t2_wb_release", 32'(in_ready), 32'd1);
        step();
        wb(1'b0, 5'd0, 32'h0);
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_op1",   out_op1,        32'hCAFE);
        #1;
        chk("t2_busy_cleared", 32'(in_ready), 32'd1);
        step();
        chk("t2_rf_op1", out_op1, 32'hCAFE);

        // 3: write-back to non-busy x3 forwarded ahead of stale rf_q1
        drive(1'b1, 5'd0, 5'd3, 5'd0, 1'b0);
        wb(1'b1, 5'd3, 32'hBEEF);
        #1;
        chk("t3_rf_q1_old", rf_q1, 32'd0);
        step();
        wb(1'b0, 5'd0, 32'h0);
        chk("t3_op2", out_op2, 32'hBEEF);
        chk("t3_op1", out_op1, 32'd0);

        // 4: back-pressure holds the output and blocks intake
        out_ready = 1'b0;
        drive(1'b1, 5'd5, 5'd3, 5'd2, 1'b0);
        #1;
        chk("t4_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_op2",   out_op2,        32'hBEEF);
            chk("t4_hold_op1",   out_op1,        32'd0);
            chk("t4_hold_rdy",   32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("t4_release_rdy", 32'(in_ready), 32'd1);
        step();
        chk("t4_new_op1", out_op1,     32'h1234);
        chk("t4_new_op2", out_op2,     32'hBEEF);
        chk("t4_new_rd",  32'(out_rd), 32'd2);

        // 5: set wins over same-cycle clear for x9
        drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
        wb(1'b1, 5'd9, 32'h99);
        step();
        wb(1'b0, 5'd0, 32'h0);
        drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b0);
        #1;
        chk("t5_set_wins", 32'(in_ready), 32'd0);
        wb(1'b1, 5'd9, 32'h55);
        step();
        wb(1'b0, 5'd0, 32'h0);
        chk("t5_op1", out_op1, 32'h55);

        // 5b: rd=0 never becomes busy; rs=0 never stalls; wb to x0 is ignored
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        step();
        chk("t5_rd0_we", 32'(out_rd_we), 32'd1);
        drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b0);
        wb(1'b1, 5'd0, 32'hFFFF);
        #1;
        chk("t5_x0_ready", 32'(in_ready), 32'd1);
        step();
        wb(1'b0, 5'd0, 32'h0);
        chk("t5_x0_op1", out_op1, 32'd0);

        // 5c: rs1 == rs2 reads the same value into both operands
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        step();
        chk("t5_same_op1", out_op1, 32'h1234);
        chk("t5_same_op2", out_op2, 32'h1234);

        // 6: asynchronous reset with busy[4] set and output pending
        drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
        step();
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        drive(1'b1, 5'd4, 5'd0, 5'd0, 1'b0);
        #1;
        chk("t6_pre_stall", 32'(in_ready), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_ready", 32'(in_ready),  32'd1);
        chk("t6_async_rd",    32'(out_rd),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
